mem2axi_master: RTL

MEM2AXI_MASTER -- requirements
Module: mem2axi_master

---
 rtl/mem2axi_master_if.sv | 37 +++
 rtl/mem2axi_master.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem2axi_master_if.sv
// axi_lite_if: AXI4-Lite channel bundle (AR, R, AW, W, B).
//   master modport: drives arvalid/araddr, rready, awvalid/awaddr,
//                   wvalid/wdata/wstrb, bready; observes the readies,
//                   rvalid/rdata/rresp and bvalid/bresp.
//   slave modport:  the mirror image.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/mem2axi_master.sv
// mem2axi_master: bridges a simple single-outstanding core memory request
// port onto an AXI4-Lite master.
//   clk, rst      : clock, synchronous active-high reset
//   req_*         : core request (valid/ready handshake, wen, addr, wdata, wstrb)
//   rsp_*         : one-cycle completion pulse with read data and error flag
//   axi           : AXI4-Lite master port
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | ready for a core request
// ST_AR      | read address offered, waiting for arready
// ST_R       | waiting for read data (rvalid)
// ST_AW_W    | write address and data both offered
// ST_W_ONLY  | address taken, data still offered
// ST_AW_ONLY | data taken, address still offered
// ST_B       | waiting for write response (bvalid)
module mem2axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  axi_lite_if.master          axi
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AR      = 3'd1,
    ST_R       = 3'd2,
    ST_AW_W    = 3'd3,
    ST_W_ONLY  = 3'd4,
    ST_AW_ONLY = 3'd5,
    ST_B       = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                wen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        wen_q   <= req_wen;
      end
    end
  end

  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    // Payloads come straight from the capture registers, so they cannot
    // move while a valid is waiting for its ready.
    axi.araddr  = addr_q;
    axi.awaddr  = addr_q;
    axi.wdata   = wdata_q;
    axi.wstrb   = wstrb_q;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = req_wen ? ST_AW_W : ST_AR;
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_n = ST_R;
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          rsp_valid = 1'b1;
          // wen_q is always 0 here; the guard keeps write data paths from
          // ever exposing rdata.
          rsp_rdata = wen_q ? '0 : axi.rdata;
          rsp_err   = (axi.rresp != 2'b00);
          state_n   = ST_IDLE;
        end
      end
      ST_AW_W: begin
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        case ({axi.awready, axi.wready})
          2'b11:   state_n = ST_B;
          2'b10:   state_n = ST_W_ONLY;
          2'b01:   state_n = ST_AW_ONLY;
          default: state_n = ST_AW_W;
        endcase
      end
      ST_W_ONLY: begin
        axi.wvalid = 1'b1;
        if (axi.wready) state_n = ST_B;
      end
      ST_AW_ONLY: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_n = ST_B;
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          rsp_valid = 1'b1;
          rsp_err   = (axi.bresp != 2'b00);
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
